// File: rtl/n_bit_comp_pkg.sv
// -----------------------------------------------------------------------------
// n_bit_comp_pkg
// Shared types and helpers for the registered N-bit magnitude comparator.
//   cmp_res_t       : three-way compare result produced by the combinational core
//   cmp_flags_t     : {gt, ls, eq} flag bundle as registered by the top level
//   CMP_RESET_FLAGS : flag value held while in reset (all flags low)
//   res_to_flags()  : decodes a cmp_res_t into one-hot {gt, ls, eq}
// Build option: SIGNED_CMP_EN (see n_bit_comp_core) does not affect this package.
// -----------------------------------------------------------------------------
package n_bit_comp_pkg;

   typedef enum logic [1:0] {
      CMP_EQ = 2'd0,
      CMP_GT = 2'd1,
      CMP_LS = 2'd2
   } cmp_res_t;

   typedef struct packed {
      logic gt;
      logic ls;
      logic eq;
   } cmp_flags_t;

   localparam cmp_flags_t CMP_RESET_FLAGS = 3'b000;

   // The unused encoding 2'b11 decodes to eq so the flags stay one-hot even
   // if the result bus were ever corrupted.
   function automatic cmp_flags_t res_to_flags(input cmp_res_t res);
      cmp_flags_t flags;
      flags = CMP_RESET_FLAGS;
      case (res)
         CMP_GT:  flags.gt = 1'b1;
         CMP_LS:  flags.ls = 1'b1;
         default: flags.eq = 1'b1;
      endcase
      return flags;
   endfunction

endpackage

// File: rtl/n_bit_comp_core.sv
// -----------------------------------------------------------------------------
// n_bit_comp_core
// Purely combinational three-way magnitude compare of two N-bit operands.
//   N    : operand width, N >= 1
//   a, b : operands
//   res  : CMP_GT (a > b), CMP_LS (a < b) or CMP_EQ (a == b)
// Build option: `define SIGNED_CMP_EN for two's-complement operands; otherwise
// operands are unsigned magnitudes.
//
// Each bit yields a {gt, lt} pair; pairs are merged pairwise in a binary tree
// where the more significant non-equal pair wins. The tree is stored heap-style:
// node n has children 2n (less significant half) and 2n+1 (more significant
// half); leaves sit at P..2P-1 and node 1 is the root.
// -----------------------------------------------------------------------------
module n_bit_comp_core
   import n_bit_comp_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output cmp_res_t     res
);

   localparam int LEVELS = $clog2(N);
   localparam int P      = 1 << LEVELS;   // leaf count, N padded to a power of two

   logic [N-1:0] a_m;
   logic [N-1:0] b_m;

`ifdef SIGNED_CMP_EN
   // Flipping the sign bits maps two's-complement order onto unsigned order,
   // so the same unsigned tree serves both builds.
   localparam logic [N-1:0] MSB_MASK = ~({N{1'b1}} >> 1);
   assign a_m = a ^ MSB_MASK;
   assign b_m = b ^ MSB_MASK;
`else
   assign a_m = a;
   assign b_m = b;
`endif

   logic [2*P-1:1] g_node;
   logic [2*P-1:1] l_node;

   for (genvar i = 0; i < P; i++) begin : g_leaf
      if (i < N) begin : g_bit
         assign g_node[P+i] = a_m[i] & ~b_m[i];
         assign l_node[P+i] = ~a_m[i] & b_m[i];
      end else begin : g_pad
         // Padding bits compare equal and never influence the result.
         assign g_node[P+i] = 1'b0;
         assign l_node[P+i] = 1'b0;
      end
   end

   for (genvar n = 1; n < P; n++) begin : g_merge
      // gt and lt of one node are never both set, so the high pair wins unless
      // it is equal, in which case the low pair decides.
      assign g_node[n] = g_node[2*n+1] | (~l_node[2*n+1] & g_node[2*n]);
      assign l_node[n] = l_node[2*n+1] | (~g_node[2*n+1] & l_node[2*n]);
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      res = CMP_EQ;
      if (g_node[1]) begin
         res = CMP_GT;
      end else if (l_node[1]) begin
         res = CMP_LS;
      end
   end

endmodule

// File: rtl/n_bit_comparator.sv
// -----------------------------------------------------------------------------
// n_bit_comparator
// Registered three-way magnitude comparator, one cycle of latency.
//   N      : operand width, N >= 1 (default 8)
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears all flags
//   A, B   : operands, sampled on every rising clk edge
//   gt     : registered A > B
//   ls     : registered A < B
//   eq     : registered A == B
// Exactly one flag is high after the first clock edge out of reset; all flags
// are low while in reset. Flags come straight from flops, so they are
// glitch-free.
// Build option: `define SIGNED_CMP_EN for a two's-complement compare; the
// default build compares unsigned magnitudes.
// -----------------------------------------------------------------------------
module n_bit_comparator
   import n_bit_comp_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         gt,
   output logic         ls,
   output logic         eq
);

   cmp_res_t   res;
   cmp_flags_t flags_d;
   cmp_flags_t flags_q;

   n_bit_comp_core #(
      .N (N)
   ) u_core (
      .a   (A),
      .b   (B),
      .res (res)
   );

   always_comb begin
      flags_d = res_to_flags(res);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples its input before any of them change on this edge.
      if (!rst_n) begin
         flags_q <= CMP_RESET_FLAGS;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign gt = flags_q.gt;
   assign ls = flags_q.ls;
   assign eq = flags_q.eq;

endmodule

// File: tb/tb_n_bit_comparator.sv
// -----------------------------------------------------------------------------
// tb_n_bit_comparator
// Self-checking bench for n_bit_comparator. An N=8 instance is driven from a
// vector table and a few hand-written multi-cycle sequences (reset hold and
// release, operand changes between edges, asynchronous clear). N=1, 8 and 33
// instances then run random vectors against a reference model built on the
// language's own >, <, == operators. Expected flags are queued when operands
// are driven and popped when the registered result is sampled.
// Build option: `define SIGNED_CMP_EN selects signed expectations.
// -----------------------------------------------------------------------------
module tb_n_bit_comparator;

   localparam logic [2:0] F_NONE = 3'b000;   // {gt, ls, eq}
   localparam logic [2:0] F_GT   = 3'b100;
   localparam logic [2:0] F_LS   = 3'b010;
   localparam logic [2:0] F_EQ   = 3'b001;

`ifdef SIGNED_CMP_EN
   // A has the sign bit set, B does not: A is negative, so A < B.
   localparam logic [2:0] F_AMSB = F_LS;
   localparam logic [2:0] F_BMSB = F_GT;
`else
   localparam logic [2:0] F_AMSB = F_GT;
   localparam logic [2:0] F_BMSB = F_LS;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      logic [2:0] exp;
      string      name;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  a8,  b8;
   logic [0:0]  a1,  b1;
   logic [32:0] a33, b33;
   logic        gt8,  ls8,  eq8;
   logic        gt1,  ls1,  eq1;
   logic        gt33, ls33, eq33;
   logic [2:0]  f8, f1, f33;

   int total = 0;
   int bad   = 0;

   sb_t  sb8[$];
   sb_t  sb1[$];
   sb_t  sb33[$];
   vec_t vecs[$];

   assign f8  = {gt8,  ls8,  eq8};
   assign f1  = {gt1,  ls1,  eq1};
   assign f33 = {gt33, ls33, eq33};

   n_bit_comparator #(.N(8)) dut8 (
      .clk (clk), .rst_n (rst_n), .A (a8), .B (b8),
      .gt (gt8), .ls (ls8), .eq (eq8)
   );

   n_bit_comparator #(.N(1)) dut1 (
      .clk (clk), .rst_n (rst_n), .A (a1), .B (b1),
      .gt (gt1), .ls (ls1), .eq (eq1)
   );

   n_bit_comparator #(.N(33)) dut33 (
      .clk (clk), .rst_n (rst_n), .A (a33), .B (b33),
      .gt (gt33), .ls (ls33), .eq (eq33)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got {gt,ls,eq}=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: n-bit operands zero-extended into 64 bits.
   function automatic logic [2:0] ref_flags(input logic [63:0] a, input logic [63:0] b,
                                            input int n);
`ifdef SIGNED_CMP_EN
      longint sa;
      longint sb;
      sa = $signed(a << (64 - n)) >>> (64 - n);
      sb = $signed(b << (64 - n)) >>> (64 - n);
      return {sa > sb, sa < sb, sa == sb};
`else
      return {a > b, a < b, a == b};
`endif
   endfunction

   task automatic pop_check8();
      sb_t item;
      if (sb8.size() == 0) begin
         total++;
         bad++;
         $display("FAIL sb8_empty: got no queued expectation, required one");
      end else begin
         item = sb8.pop_front();
         check(item.name, f8, item.exp);
      end
   endtask

   // Drive one N=8 vector on the falling edge, check it after the next rise.
   task automatic apply8(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] exp, input string name);
      @(negedge clk);
      a8 = a;
      b8 = b;
      sb8.push_back('{exp, name});
      @(posedge clk);
      #1;
      pop_check8();
   endtask

   initial begin
      logic [63:0] r;
      sb_t         item;

      vecs.push_back('{8'hA1, 8'hA1, F_EQ,   "eq_a1"});
      vecs.push_back('{8'h00, 8'h00, F_EQ,   "eq_zero"});
      vecs.push_back('{8'hFF, 8'hFF, F_EQ,   "eq_ones"});
      vecs.push_back('{8'h0C, 8'h0A, F_GT,   "gt_0c_0a"});
      vecs.push_back('{8'h03, 8'h04, F_LS,   "ls_03_04"});
      vecs.push_back('{8'h01, 8'h02, F_LS,   "ls_01_02"});
      vecs.push_back('{8'hFF, 8'h7F, F_AMSB, "ff_vs_7f"});
      vecs.push_back('{8'h80, 8'h7F, F_AMSB, "80_vs_7f"});
      vecs.push_back('{8'h80, 8'h00, F_AMSB, "msb_only_a"});
      vecs.push_back('{8'h00, 8'h80, F_BMSB, "msb_only_b"});
      vecs.push_back('{8'h55, 8'h54, F_GT,   "lsb_only_a"});
      vecs.push_back('{8'h54, 8'h55, F_LS,   "lsb_only_b"});
      vecs.push_back('{8'h7F, 8'h7F, F_EQ,   "eq_7f"});

      rst_n = 1'b0;
      a8  = 8'hA1;
      b8  = 8'hA1;
      a1  = '0;
      b1  = '0;
      a33 = '0;
      b33 = '0;

      // Flags stay low through clock edges while reset is held.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", f8, F_NONE);
      end

      // First edge with reset released gives a valid result.
      @(negedge clk);
      rst_n = 1'b1;
      sb8.push_back('{F_EQ, "reset_release"});
      @(posedge clk);
      #1;
      pop_check8();

      for (int i = 0; i < vecs.size(); i++) begin
         apply8(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
      end

      // Operand change between edges must not reach the flags early.
      apply8(8'h0C, 8'h0A, F_GT, "pre_change_gt");
      @(negedge clk);
      a8 = 8'h03;
      b8 = 8'h04;
      sb8.push_back('{F_LS, "post_change_ls"});
      #1;
      check("hold_after_change", f8, F_GT);
      #3;
      check("hold_before_edge", f8, F_GT);
      @(posedge clk);
      #1;
      pop_check8();

      // Reset asserted mid-cycle clears flags with no clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", f8, F_NONE);
      @(posedge clk);
      #1;
      check("clear_held", f8, F_NONE);
      @(negedge clk);
      rst_n = 1'b1;
      sb8.push_back('{F_LS, "rerelease_ls"});
      @(posedge clk);
      #1;
      pop_check8();

      // Random vectors on all widths; B sometimes copies A to cover equality.
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         r   = {$urandom(), $urandom()};
         a8  = r[7:0];
         a1  = r[8:8];
         a33 = r[41:9];
         r   = {$urandom(), $urandom()};
         b8  = (r[63:62] == 2'b00) ? a8  : r[7:0];
         b1  = r[8:8];
         b33 = (r[61:60] == 2'b00) ? a33 : r[42:10];
         sb8.push_back('{ref_flags(64'(a8),  64'(b8),  8),  "rand8"});
         sb1.push_back('{ref_flags(64'(a1),  64'(b1),  1),  "rand1"});
         sb33.push_back('{ref_flags(64'(a33), 64'(b33), 33), "rand33"});
         @(posedge clk);
         #1;
         check("onehot8",  3'($countones(f8)),  3'd1);
         check("onehot1",  3'($countones(f1)),  3'd1);
         check("onehot33", 3'($countones(f33)), 3'd1);
         pop_check8();
         item = sb1.pop_front();
         check(item.name, f1, item.exp);
         item = sb33.pop_front();
         check(item.name, f33, item.exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
